// File: rtl/memory_request_arbiter.sv
// memory_request_arbiter: shares the single MemoryController request port between I-fetch and D requesters.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed D-over-I priority.
module memory_request_arbiter #(
  parameter int addressWidth    = 64,
  parameter int blockWidth      = 256,
  parameter int blockOffsetBits = 5,
  parameter int timeoutCycles   = 255
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [addressWidth-1:0] iAddress_i,
  input  logic                    iRequest_i,
  output logic                    iAccept_o,
  output logic                    iBlockValid_o,
  input  logic [addressWidth-1:0] dAddress_i,
  input  logic [blockWidth-1:0]   dData_i,
  input  logic                    dIsWrite_i,
  input  logic                    dRequest_i,
  output logic                    dAccept_o,
  output logic                    dBlockValid_o,
  output logic                    dWriteDone_o,
  output logic [blockWidth-1:0]   block_o,
  output logic                    timeout_o,
  output logic [addressWidth-1:0] address_o,
  output logic [blockWidth-1:0]   data_o,
  output logic                    isMemWrite_o,
  output logic                    requestEnable_o,
  input  logic [blockWidth-1:0]   block_i,
  input  logic [addressWidth-1:0] blockAddress_i,
  input  logic                    blockOutEnable_i,
  input  logic                    isMemoryEngaged_i,
  output logic [1:0]              debugState_o
);

  // Handshake: a requester raises xRequest_i with its operands stable and holds it until the
  // single-cycle xAccept_o pulse; it drops the request the following cycle. Completion is reported
  // by a single-cycle xBlockValid_o / dWriteDone_o pulse; block_o is meaningful only during that pulse.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  localparam logic [7:0] timerLast = 8'(timeoutCycles - 1);

  state_t     state;
  state_t     stateNext;
  logic       ownerD;
  logic       engagedSeen;
  logic [7:0] timer;

  logic pickD;
  logic grantI;
  logic grantD;
  logic readDone;
  logic writeDone;
  logic timeoutFire;

  assign debugState_o = state;

`ifdef ARB_ROUND_ROBIN_EN
  // lastOwnerD resets to I so that D wins the first contention.
  logic lastOwnerD;

  assign pickD = dRequest_i && (!iRequest_i || !lastOwnerD);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      lastOwnerD <= 1'b0;
    end else if (grantI || grantD) begin
      lastOwnerD <= grantD;
    end
  end
`else
  assign pickD = dRequest_i;
`endif

  always_comb begin
    stateNext   = state;
    grantI      = 1'b0;
    grantD      = 1'b0;
    readDone    = 1'b0;
    writeDone   = 1'b0;
    timeoutFire = 1'b0;
    unique case (state)
      IDLE: begin
        if (!isMemoryEngaged_i && (iRequest_i || dRequest_i)) begin
          grantD    = pickD;
          grantI    = !pickD;
          stateNext = ISSUE;
        end
      end
      ISSUE: stateNext = WAIT_RESP;
      WAIT_RESP: begin
        // A write is finished only once the controller has been seen busy and then idle again.
        if (isMemWrite_o) begin
          writeDone = engagedSeen && !isMemoryEngaged_i;
        end else begin
          readDone = blockOutEnable_i && (blockAddress_i == address_o);
        end
        if (readDone || writeDone) begin
          stateNext = IDLE;
        end else if (timer == timerLast) begin
          timeoutFire = 1'b1;
          stateNext   = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state           <= IDLE;
      ownerD          <= 1'b0;
      engagedSeen     <= 1'b0;
      timer           <= '0;
      iAccept_o       <= 1'b0;
      dAccept_o       <= 1'b0;
      requestEnable_o <= 1'b0;
      iBlockValid_o   <= 1'b0;
      dBlockValid_o   <= 1'b0;
      dWriteDone_o    <= 1'b0;
      timeout_o       <= 1'b0;
      block_o         <= '0;
      address_o       <= '0;
      data_o          <= '0;
      isMemWrite_o    <= 1'b0;
    end else begin
      state           <= stateNext;
      iAccept_o       <= grantI;
      dAccept_o       <= grantD;
      requestEnable_o <= grantI || grantD;
      iBlockValid_o   <= readDone && !ownerD;
      dBlockValid_o   <= readDone && ownerD;
      dWriteDone_o    <= writeDone;

      if (grantD) begin
        address_o    <= {dAddress_i[addressWidth-1:blockOffsetBits], {blockOffsetBits{1'b0}}};
        data_o       <= dData_i;
        isMemWrite_o <= dIsWrite_i;
        ownerD       <= 1'b1;
      end else if (grantI) begin
        address_o    <= {iAddress_i[addressWidth-1:blockOffsetBits], {blockOffsetBits{1'b0}}};
        data_o       <= '0;
        isMemWrite_o <= 1'b0;
        ownerD       <= 1'b0;
      end

      if (state == ISSUE) begin
        timer       <= '0;
        engagedSeen <= 1'b0;
      end else if (state == WAIT_RESP) begin
        timer <= timer + 8'd1;
        if (isMemWrite_o && isMemoryEngaged_i) begin
          engagedSeen <= 1'b1;
        end
      end

      if (readDone) begin
        block_o <= block_i;
      end
      if (timeoutFire) begin
        timeout_o <= 1'b1;
      end
    end
  end

endmodule
